// File: rtl/busca_instrucao_pkg.sv
// Shared definitions for the fetch stage: FSM state encoding, tipo codes
// and the opcode/funct3 field positions used to pre-decode the fetched word.
package riscv_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      HOLD  = 2'd2
   } estado_t;

   localparam logic [3:0] TIPO_LW  = 4'b0000;
   localparam logic [3:0] TIPO_SW  = 4'b0010;
   localparam logic [3:0] TIPO_R   = 4'b0011;
   localparam logic [3:0] TIPO_BEQ = 4'b0110;

   localparam int OPC_HI = 6;
   localparam int OPC_LO = 4;
   localparam int F3_HI  = 14;
   localparam int F3_LO  = 12;

   function automatic logic [3:0] tipo_de(input logic [31:0] w);
      return {1'b0, w[OPC_HI:OPC_LO]};
   endfunction

   function automatic logic [2:0] funct3_de(input logic [31:0] w);
      return w[F3_HI:F3_LO];
   endfunction

endpackage

// File: rtl/busca_instrucao_pc_reg.sv
// Program counter: reset value, sequential +4 step and branch redirect.
// A redirect always wins over the increment; its low two bits are cleared
// so the PC stays word aligned.
module pc_reg #(
   parameter int              PC_W     = 32,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            inc,
   input  logic            redirect,
   input  logic [PC_W-1:0] target,
   output logic [PC_W-1:0] pc
);

   localparam logic [PC_W-1:0] ALIGN_MASK = ~(PC_W'(3));

   // PC update: redirect, else step to the next word (wraps naturally)
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         pc <= RESET_PC;
      else if (redirect)
         pc <= target & ALIGN_MASK;
      else if (inc)
         pc <= pc + PC_W'(4);
   end

endmodule

// File: rtl/busca_instrucao.sv
// Instruction fetch stage: one outstanding word read at a time over a
// req/ack handshake, result held on a valid/ready handshake to decode.
// Optional build macro IFETCH_STALL_CNT_EN adds stall/fetch counters.
//
//  state | meaning
//  FETCH | issue request for pc (first cycle after reset stays idle)
//  WAIT  | request held until imem_ack; drop data if it went stale
//  HOLD  | instr valid to decode until accepted or flushed by a branch
module busca_instrucao
   import riscv_pkg::*;
#(
   parameter int              PC_W     = 32,
   parameter logic [PC_W-1:0] RESET_PC = 32'h0
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [31:0]     instr,
   output logic [PC_W-1:0] instr_pc,
   output logic [3:0]      tipo,
   output logic [2:0]      funct3,
   input  logic            branch_taken,
   input  logic [PC_W-1:0] branch_target
`ifdef IFETCH_STALL_CNT_EN
   ,
   output logic [31:0]     stall_cnt,
   output logic [31:0]     fetch_cnt
`endif
);

   estado_t         state, state_nxt;
   logic            discard, discard_nxt;
   logic            ativo;
   logic            pc_inc, captura, aceita;
   logic [PC_W-1:0] pc, fetch_addr;

   pc_reg #(.PC_W(PC_W), .RESET_PC(RESET_PC)) u_pc (
      .clk      (clk),
      .reset    (reset),
      .inc      (pc_inc),
      .redirect (branch_taken),
      .target   (branch_target),
      .pc       (pc)
   );

   // ativo keeps imem_req low for the first cycle after reset release
   assign imem_req    = ativo && (state != HOLD);
   assign imem_addr   = (state == FETCH) ? pc : fetch_addr;
   assign instr_valid = (state == HOLD);
   assign tipo        = tipo_de(instr);
   assign funct3      = funct3_de(instr);

   // next-state logic; a branch makes any in-flight or held word stale
   always_comb begin
      state_nxt   = state;
      discard_nxt = discard;
      pc_inc      = 1'b0;
      captura     = 1'b0;
      aceita      = 1'b0;
      case (state)
         FETCH: begin
            if (ativo) begin
               captura   = 1'b1;
               state_nxt = WAIT;
               if (branch_taken)
                  discard_nxt = 1'b1;
            end
         end
         WAIT: begin
            if (imem_ack) begin
               state_nxt   = FETCH;
               discard_nxt = 1'b0;
               if (!discard && !branch_taken) begin
                  aceita    = 1'b1;
                  pc_inc    = 1'b1;
                  state_nxt = HOLD;
               end
            end else if (branch_taken) begin
               discard_nxt = 1'b1;
            end
         end
         HOLD: begin
            if (branch_taken || instr_ready)
               state_nxt = FETCH;
         end
         default: state_nxt = FETCH;
      endcase
   end

   // state register, stale-response flag and post-reset idle guard
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= FETCH;
         discard <= 1'b0;
         ativo   <= 1'b0;
      end else begin
         state   <= state_nxt;
         discard <= discard_nxt;
         ativo   <= 1'b1;
      end
   end

   // fetch address frozen for the life of the request, even across redirects
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         fetch_addr <= RESET_PC;
      else if (captura)
         fetch_addr <= pc;
   end

   // instruction latch for the word handed to decode
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instr    <= '0;
         instr_pc <= '0;
      end else if (aceita) begin
         instr    <= imem_rdata;
         instr_pc <= fetch_addr;
      end
   end

`ifdef IFETCH_STALL_CNT_EN
   // saturating stall and handoff counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= '0;
         fetch_cnt <= '0;
      end else begin
         if (((state == WAIT && !imem_ack) || (state == HOLD && !instr_ready))
             && stall_cnt != '1)
            stall_cnt <= stall_cnt + 32'd1;
         if (instr_valid && instr_ready && fetch_cnt != '1)
            fetch_cnt <= fetch_cnt + 32'd1;
      end
   end
`endif

endmodule
